// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence-detection run controller.
//   - default widths for pattern, match counter and timeout counter
//   - len_w(): width needed to hold a pattern length of 0..pat_w
//   - one-hot controller state encoding
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned TO_W_DEF  = 16;

  // Length field must represent pat_w itself, hence the +1.
  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ARM  = 4'b0010,
    ST_RUN  = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: bit history, saturating bits-seen counter and a
// length-masked comparator.
// Ports:
//   clk, rst      clock, async active-high reset
//   clear         synchronous clear of history and bits-seen counter
//   shift_en      accept din this cycle
//   din           serial data bit
//   pattern, len  pattern (bit len-1 first, bit 0 last) and its length
//   overlap       0: restart bits-seen after every match
//   match_c       combinational: the bit being shifted in completes a match
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_W = PAT_W_DEF,
  localparam int unsigned LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match_c
);

  // Only PAT_W-1 past bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] bits_q, bits_d;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] bits_new;

  // Window compare and next-state for history and bits-seen counter.
  always_comb begin
    hist_d   = hist_q;
    bits_d   = bits_q;
    window   = {hist_q, din};
    bits_new = (bits_q >= len) ? len : bits_q + LEN_W'(1);
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match_c = shift_en && (bits_new >= len) && (((window ^ pattern) & mask) == '0);

    if (clear) begin
      hist_d = '0;
      bits_d = '0;
    end else if (shift_en) begin
      hist_d = window[PAT_W-2:0];
      bits_d = (match_c && !overlap) ? '0 : bits_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      bits_q <= '0;
    end else begin
      hist_q <= hist_d;
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial sequence-detection path. Latches pattern and
// run configuration on start, gates din into the matcher during RUN, counts
// matches and ends the run on target count, idle timeout or abort.
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_pattern/len/overlap    matcher configuration (shadowed at start)
//   cfg_target, cfg_timeout    run end conditions, 0 = disabled
//   start, abort               run control
//   din, din_valid             serial input
//   busy, match, match_cnt     run status (registered)
//   done, timed_out, cfg_err   completion / error flags (registered)
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_W = PAT_W_DEF,
  parameter  int unsigned CNT_W = CNT_W_DEF,
  parameter  int unsigned TO_W  = TO_W_DEF,
  localparam int unsigned LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timed_out,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             cfg_err_q, cfg_err_d;

  logic             core_clear_c;
  logic             shift_en_c;
  logic             core_match_c;
  logic             len_ok_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [TO_W-1:0]  idle_inc_c;

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (core_clear_c),
    .shift_en (shift_en_c),
    .din      (din),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .match_c  (core_match_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    ovl_d        = ovl_q;
    tgt_d        = tgt_q;
    tmo_d        = tmo_q;
    idle_d       = idle_q;
    cnt_d        = cnt_q;
    timed_out_d  = timed_out_q;
    match_d      = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    core_clear_c = 1'b0;
    shift_en_c   = (state_q == ST_RUN) && din_valid && !abort;
    len_ok_c     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    cnt_inc_c    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    idle_inc_c   = idle_q + TO_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            state_d = ST_ARM;
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            tgt_d   = cfg_target;
            tmo_d   = cfg_timeout;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          core_clear_c = 1'b1;
          cnt_d        = '0;
          idle_d       = '0;
          timed_out_d  = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (core_match_c) begin
          // A match restarts the idle window and outranks a coincident timeout.
          match_d = 1'b1;
          cnt_d   = cnt_inc_c;
          idle_d  = '0;
          if ((tgt_q != '0) && (cnt_inc_c == tgt_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          idle_d = idle_inc_c;
          if ((tmo_q != '0) && (idle_inc_c == tmo_q)) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            timed_out_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      tmo_q       <= '0;
      idle_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      tgt_q       <= tgt_d;
      tmo_q       <= tmo_d;
      idle_q      <= idle_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      match_q     <= match_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with hand-computed expected values.
module tb_seq_det_ctrl;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             busy, match, done, timed_out, cfg_err;
  logic [CNT_W-1:0] match_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mv, dv;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .din         (din),
    .din_valid   (din_valid),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .timed_out   (timed_out),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run; returns with the DUT in RUN.
  task automatic start_run(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic [CNT_W-1:0] tgt,
                           input logic [TO_W-1:0] tmo);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    cfg_timeout = tmo;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    tick();
  endtask

  // Feed n valid bits, bits[n-1] first; record match/done after each bit.
  task automatic feed(input logic [31:0] bits, input int n,
                      output logic [31:0] m, output logic [31:0] d);
    m = '0;
    d = '0;
    for (int k = 0; k < n; k++) begin
      din       = bits[n-1-k];
      din_valid = 1'b1;
      tick();
      m[n-1-k] = match;
      d[n-1-k] = done;
    end
    din_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("reset_outs", {26'd0, busy, match, done, timed_out, cfg_err, 1'b0}, 32'd0);
    check("reset_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // 1: overlapping 0101, target 2
    start_run(8'b0101, 4'd4, 1'b1, 8'd2, 16'd0);
    check("t1_busy", 32'(busy), 32'd1);
    feed(32'b010101, 6, mv, dv);
    check("t1_match_vec", mv, 32'b000101);
    check("t1_done_vec", dv, 32'b000001);
    check("t1_cnt", 32'(match_cnt), 32'd2);
    tick();
    check("t1_idle", {30'd0, busy, done}, 32'd0);
    check("t1_cnt_hold", 32'(match_cnt), 32'd2);

    // 2: non-overlapping, target 2
    start_run(8'b0101, 4'd4, 1'b0, 8'd2, 16'd0);
    check("t2_cnt_clr", 32'(match_cnt), 32'd0);
    feed(32'b01010101, 8, mv, dv);
    check("t2_match_vec", mv, 32'b00010001);
    check("t2_done_vec", dv, 32'b00000001);
    check("t2_cnt", 32'(match_cnt), 32'd2);
    tick();

    // 3: timeout after 10 idle RUN cycles
    start_run(8'b0101, 4'd4, 1'b1, 8'd0, 16'd10);
    feed(32'h3FF, 10, mv, dv);
    check("t3_match_vec", mv, 32'd0);
    check("t3_done_vec", dv, 32'b0000000001);
    check("t3_timed_out", 32'(timed_out), 32'd1);
    tick();
    check("t3_after", {29'd0, busy, done, timed_out}, 32'b001);

    // 4: abort after one match; abort beats a coincident match
    start_run(8'b0101, 4'd4, 1'b1, 8'd0, 16'd0);
    check("t4_timed_out_clr", 32'(timed_out), 32'd0);
    feed(32'b01010, 5, mv, dv);
    check("t4_match_vec", mv, 32'b00010);
    abort     = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    abort     = 1'b0;
    din_valid = 1'b0;
    check("t4_abort", {29'd0, busy, match, done}, 32'd0);
    check("t4_cnt_hold", 32'(match_cnt), 32'd1);
    tick();
    check("t4_no_done", {30'd0, busy, done}, 32'd0);

    // 5: illegal lengths rejected; start while busy ignored
    cfg_len = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t5_len0_err", {30'd0, cfg_err, busy}, 32'b10);
    tick();
    check("t5_err_pulse", {30'd0, cfg_err, busy}, 32'b00);
    cfg_len = 4'd9;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t5_len9_err", {30'd0, cfg_err, busy}, 32'b10);
    tick();
    start_run(8'b0101, 4'd4, 1'b1, 8'd1, 16'd0);
    feed(32'b01, 2, mv, dv);
    cfg_pattern = 8'b11;
    cfg_len     = 4'd2;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check("t5_busy_start", {30'd0, busy, cfg_err}, 32'b10);
    feed(32'b01, 2, mv, dv);
    check("t5_match_vec", mv, 32'b01);
    check("t5_done_vec", dv, 32'b01);
    check("t5_cnt", 32'(match_cnt), 32'd1);
    tick();

    // 6: async reset mid-run, then 20 ones against an 8-bit all-ones pattern
    start_run(8'hFF, 4'd8, 1'b1, 8'd3, 16'd0);
    feed(32'h1F, 5, mv, dv);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {27'd0, busy, match, done, timed_out, cfg_err}, 32'd0);
    check("t6_rst_cnt", 32'(match_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    start_run(8'hFF, 4'd8, 1'b1, 8'd0, 16'd0);
    feed(32'hFFFFF, 20, mv, dv);
    check("t6_match_vec", mv, 32'h01FFF);
    check("t6_cnt", 32'(match_cnt), 32'd13);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
